// File: rtl/match_hist_sequencer.sv
// Memory-port sequencer: loads a 4-bit pattern, scans a byte range counting
// nibble-window matches per byte, then writes the 1..5-match histogram back.
module match_hist_sequencer #(
    parameter logic [7:0]  PAT_ADDR  = 8'd9,
    parameter logic [7:0]  HIST_ADDR = 8'd10,
    parameter logic [7:0]  SCAN_BASE = 8'd32,
    parameter int unsigned NUM_BYTES = 64
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] MemRdData,
    output logic [7:0] MemAddr,
    output logic       MemWrEn,
    output logic [7:0] MemWrData,
    output logic       Busy,
    output logic       Done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SCAN  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] pat_q, pat_d;
    logic [7:0] idx_q, idx_d;
    logic [2:0] wIdx_q, wIdx_d;
    logic       done_q, done_d;
    logic [7:0] bin_q [1:5];
    logic [7:0] bin_d [1:5];
    logic [3:0] win [5];
    logic [2:0] matchCnt;

    assign win[0] = MemRdData[7:4];
    assign win[1] = MemRdData[6:3];
    assign win[2] = MemRdData[5:2];
    assign win[3] = MemRdData[4:1];
    assign win[4] = MemRdData[3:0];

    always_comb begin
        matchCnt = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (win[k] == pat_q) begin
                matchCnt = matchCnt + 3'd1;
            end
        end
    end

    // Done comes up one cycle after entering DONE, and DONE is only left
    // once Done has been shown, so a short Start pulse always sees it.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        wIdx_d  = wIdx_q;
        done_d  = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            bin_d[b] = bin_q[b];
        end
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_LOAD;
                    idx_d   = 8'd0;
                    wIdx_d  = 3'd0;
                    for (int b = 1; b <= 5; b++) begin
                        bin_d[b] = 8'd0;
                    end
                end
            end
            ST_LOAD: begin
                pat_d   = MemRdData[3:0];
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                for (int b = 1; b <= 5; b++) begin
                    if (matchCnt == 3'(b) && bin_q[b] != 8'hFF) begin
                        bin_d[b] = bin_q[b] + 8'd1;
                    end
                end
                idx_d = idx_q + 8'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_WRITE;
                    wIdx_d  = 3'd0;
                end
            end
            ST_WRITE: begin
                wIdx_d = wIdx_q + 3'd1;
                if (wIdx_q == 3'd4) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (done_q && !Start) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        MemAddr   = 8'd0;
        MemWrEn   = 1'b0;
        MemWrData = 8'd0;
        Busy      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                MemAddr = PAT_ADDR;
                Busy    = 1'b1;
            end
            ST_SCAN: begin
                MemAddr = SCAN_BASE + idx_q;
                Busy    = 1'b1;
            end
            ST_WRITE: begin
                MemAddr = HIST_ADDR + {5'd0, wIdx_q};
                MemWrEn = 1'b1;
                Busy    = 1'b1;
                for (int b = 1; b <= 5; b++) begin
                    if (wIdx_q == 3'(b - 1)) begin
                        MemWrData = bin_q[b];
                    end
                end
            end
            default: ;
        endcase
    end

    assign Done = done_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pat_q   <= 4'd0;
            idx_q   <= 8'd0;
            wIdx_q  <= 3'd0;
            done_q  <= 1'b0;
            for (int b = 1; b <= 5; b++) begin
                bin_q[b] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            wIdx_q  <= wIdx_d;
            done_q  <= done_d;
            for (int b = 1; b <= 5; b++) begin
                bin_q[b] <= bin_d[b];
            end
        end
    end

endmodule

// File: doc/match_hist_sequencer.md
Name: match_hist_sequencer

Overview:
- Hardware sequencer that takes ownership of the data memory port and runs the 4-bit pattern-seek/histogram job without the CPU.
- Reads the pattern nibble from PAT_ADDR[3:0] and scans NUM_BYTES bytes from SCAN_BASE.
- For each byte, counts matches of the pattern against the five 4-bit windows [7:4], [6:3], [5:2], [4:1], [3:0].
- Writes histogram bins 1..5 to HIST_ADDR..HIST_ADDR+4, then raises Done. The top level muxes the data_mem port to this block while Busy=1.

Parameters:
PAT_ADDR, 9, address of pattern byte (low nibble used)
HIST_ADDR, 10, address of bin 1; bins 2..5 follow contiguously
SCAN_BASE, 32, first byte scanned
NUM_BYTES, 64, bytes scanned (1..255)

Ports:
CLK  input  1  system clock, all state updates on posedge
Reset  input  1  synchronous, active-high; returns block to IDLE
Start  input  1  level request; sampled only in IDLE
MemRdData  input  8  data_mem read data, combinational from MemAddr
MemAddr  output  8  data_mem address
MemWrEn  output  1  data_mem write enable
MemWrData  output  8  data_mem write data
Busy  output  1  block owns memory port
Done  output  1  job complete; held until Start deasserts

Behaviour:
- Reset (sync, active-high) effects, visible after the next posedge:
  - State=IDLE.
  - MemAddr=0, MemWrEn=0, MemWrData=0, Busy=0, Done=0.
  - Pattern register=0, byte index=0, bins 1..5=0.
- State machine: IDLE -> LOAD_PAT -> SCAN -> WRITE -> DONE -> IDLE.
- IDLE:
  - Outputs as in reset.
  - Start=1 at an edge: clear bins and index, go to LOAD_PAT.
- LOAD_PAT (1 cycle):
  - MemAddr=PAT_ADDR, Busy=1.
  - Pattern <= MemRdData[3:0] at the edge; go to SCAN.
- SCAN (NUM_BYTES cycles):
  - MemAddr=SCAN_BASE+index, Busy=1.
  - Per-byte match count m (0..5) is computed combinationally from MemRdData.
  - At the edge: if m>=1, bin[m] += 1. Bins are 8-bit and saturate at 255.
  - Index increments; after the index NUM_BYTES-1 cycle, go to WRITE with write index=0.
- WRITE (5 cycles):
  - MemWrEn=1, MemAddr=HIST_ADDR+w, MemWrData=bin[w+1] for w=0..4, Busy=1.
  - After w=4, go to DONE.
- DONE:
  - Done=1, Busy=0, MemWrEn=0.
  - Stay while Start=1; Start=0 at an edge -> IDLE (Done drops).
- Latency: with the Start edge as E0, Done is first high after edge E0+2+NUM_BYTES+5 (E0+71 at default). A Start held high through DONE never retriggers a job.
- Start is ignored in LOAD_PAT, SCAN and WRITE.
- Reset mid-job (any state):
  - IDLE after that edge, with no further writes; MemWrEn=0 in the following cycle.
  - Partial bins are discarded, and memory bins already written are left as-is.
- Reset and Start high at the same edge: Reset wins; block is in IDLE with Done=0.
- Address arithmetic is 8-bit and wraps modulo 256 (e.g. SCAN_BASE=250, NUM_BYTES=10 scans 250..255, 0..3).
- Bin 0 (no match) is not counted or written.
- Scan range overlapping PAT_ADDR or HIST_ADDR: the values read are those present at scan time. No writes occur before WRITE.

Test Plan:
1. All mem 0, pattern 0000, Start pulse -> bins read 0,0,0,0,64 at mem[10..14]; Done first high 71 edges after Start edge; Busy high exactly 70 cycles.
2. Pattern 0010, mem[32]=0x22 (2 matches), mem[33]=0x20 (1 match), mem[34..95]=0xFF -> mem[10..14]=1,1,0,0,0.
3. Pattern 1111, mem[32..95]=0x00 -> mem[10..14]=0,0,0,0,0; five write cycles still occur (MemWrEn high 5 cycles).
4. Reset asserted at cycle 30 of SCAN, mem[10..14] preloaded 0xAA -> MemWrEn never asserts, mem[10..14] stay 0xAA; next Start yields a correct full result.
5. Start held high 200 cycles -> exactly one job; Done stays high until Start drops, returns low 1 cycle later; second Start pulse runs a second identical job.
6. 50 runs with random pattern and random mem[32..95] -> mem[10..14] equals the bench model histogram; Start pulses during busy states have no effect.
